seg7_bin_display: RTL and testbench

//  Parametrised successor of the fixed 4-digit BCD-to-7-segment decoder.
//  - Accepts an unsigned binary value over a valid/ready handshake.
//  - Converts it to BCD with an iterative shift-add-3 (double-dabble) engine.
//  - Registers DIGITS decoded 7-segment patterns for the board display outputs.
//  - Sits between processor output registers and the display pins; holds the last value.

---
 rtl/seg7_bin_display.sv | 182 ++++++++++++++++++
 tb/tb_seg7_bin_display.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bin_display.sv
// ============================================================================
// seg7_bin_display : binary-to-BCD (double-dabble) converter with registered
//                    7-segment outputs. Optional macro: SEG7_LEADING_ZERO_BLANK_EN
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module seg7_bin_display #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic [DIGITS*7-1:0]   seg_out
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = DIGITS * 4;

    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'd0:    f_glyph = 7'b1000000;
            4'd1:    f_glyph = 7'b1111001;
            4'd2:    f_glyph = 7'b0100100;
            4'd3:    f_glyph = 7'b0110000;
            4'd4:    f_glyph = 7'b0011001;
            4'd5:    f_glyph = 7'b0010010;
            4'd6:    f_glyph = 7'b0000010;
            4'd7:    f_glyph = 7'b1111000;
            4'd8:    f_glyph = 7'b0000000;
            4'd9:    f_glyph = 7'b0010000;
            default: f_glyph = c_SEG_DASH;
        endcase
    endfunction

    function automatic logic [DIGITS*7-1:0] f_reset_seg();
        logic [DIGITS*7-1:0] s;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            s[7*i +: 7] = (i == 0) ? c_SEG_ZERO : c_SEG_BLANK;
`else
            s[7*i +: 7] = c_SEG_ZERO;
`endif
        end
        return s;
    endfunction

    state_t               r_state;
    state_t               w_next;
    logic [BIN_W-1:0]     r_shreg;
    logic [BCD_W-1:0]     r_bcd_scr;
    logic                 r_ovf_scr;
    logic [CNT_W-1:0]     r_cnt;
    logic [BCD_W-1:0]     r_bcd_out;
    logic [DIGITS*7-1:0]  r_seg_out;
    logic                 r_overflow;
    logic                 r_done;

    logic [BCD_W-1:0]     w_adj;
    logic [BCD_W-1:0]     w_bcd_next;
    logic [DIGITS*7-1:0]  w_seg_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_CONV;
            S_CONV:  if (r_cnt == CNT_W'(1)) w_next = S_LATCH;
            S_LATCH: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd_scr[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd_scr[4*i +: 4] + 4'd3;
            else
                w_adj[4*i +: 4] = r_bcd_scr[4*i +: 4];
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_lead;
`endif

    // Final result selection; leading-zero scan runs from the top digit down.
    always_comb begin
        w_bcd_next = r_ovf_scr ? {BCD_W{1'b1}} : r_bcd_scr;
        w_seg_next = '1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        w_lead = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (r_ovf_scr) begin
                w_seg_next[7*i +: 7] = c_SEG_DASH;
            end else begin
                w_seg_next[7*i +: 7] = f_glyph(r_bcd_scr[4*i +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (r_bcd_scr[4*i +: 4] != 4'd0 || i == 0)
                    w_lead = 1'b0;
                if (w_lead)
                    w_seg_next[7*i +: 7] = c_SEG_BLANK;
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shreg    <= '0;
            r_bcd_scr  <= '0;
            r_ovf_scr  <= 1'b0;
            r_cnt      <= '0;
            r_bcd_out  <= '0;
            r_seg_out  <= f_reset_seg();
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shreg   <= bin_in;
                        r_bcd_scr <= '0;
                        r_ovf_scr <= 1'b0;
                        r_cnt     <= CNT_W'(BIN_W);
                    end
                end
                S_CONV: begin
                    r_bcd_scr <= {w_adj[BCD_W-2:0], r_shreg[BIN_W-1]};
                    r_shreg   <= r_shreg << 1;
                    r_ovf_scr <= r_ovf_scr | w_adj[BCD_W-1];
                    r_cnt     <= r_cnt - CNT_W'(1);
                end
                S_LATCH: begin
                    r_bcd_out  <= w_bcd_next;
                    r_seg_out  <= w_seg_next;
                    r_overflow <= r_ovf_scr;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_CONV) || (r_state == S_LATCH);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign bcd_out  = r_bcd_out;
    assign seg_out  = r_seg_out;

endmodule

`default_nettype wire

// File: tb/tb_seg7_bin_display.sv
// ============================================================================
// tb_seg7_bin_display : directed self-checking bench for seg7_bin_display
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seg7_bin_display;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // A: defaults (16/5), B: 16/4, C: 1/1
    logic [15:0] bin_a = '0, bin_b = '0;
    logic [0:0]  bin_c = '0;
    logic        val_a = 0, val_b = 0, val_c = 0;
    logic        rdy_a, rdy_b, rdy_c, bsy_a, bsy_b, bsy_c;
    logic        dn_a, dn_b, dn_c, ov_a, ov_b, ov_c;
    logic [19:0] bcd_a;
    logic [15:0] bcd_b;
    logic [3:0]  bcd_c;
    logic [34:0] seg_a;
    logic [27:0] seg_b;
    logic [6:0]  seg_c;

    seg7_bin_display #(.BIN_W(16), .DIGITS(5)) u_dut_a (
        .clock(clock), .reset(reset), .bin_in(bin_a), .in_valid(val_a),
        .in_ready(rdy_a), .busy(bsy_a), .done(dn_a), .overflow(ov_a),
        .bcd_out(bcd_a), .seg_out(seg_a));

    seg7_bin_display #(.BIN_W(16), .DIGITS(4)) u_dut_b (
        .clock(clock), .reset(reset), .bin_in(bin_b), .in_valid(val_b),
        .in_ready(rdy_b), .busy(bsy_b), .done(dn_b), .overflow(ov_b),
        .bcd_out(bcd_b), .seg_out(seg_b));

    seg7_bin_display #(.BIN_W(1), .DIGITS(1)) u_dut_c (
        .clock(clock), .reset(reset), .bin_in(bin_c), .in_valid(val_c),
        .in_ready(rdy_c), .busy(bsy_c), .done(dn_c), .overflow(ov_c),
        .bcd_out(bcd_c), .seg_out(seg_c));

    int          sel = 0;
    logic        o_rdy, o_bsy, o_dn, o_ov;
    logic [31:0] o_bcd;
    logic [63:0] o_seg;

    always_comb begin
        o_rdy = rdy_a; o_bsy = bsy_a; o_dn = dn_a; o_ov = ov_a;
        o_bcd = 32'(bcd_a); o_seg = 64'(seg_a);
        case (sel)
            1: begin
                o_rdy = rdy_b; o_bsy = bsy_b; o_dn = dn_b; o_ov = ov_b;
                o_bcd = 32'(bcd_b); o_seg = 64'(seg_b);
            end
            2: begin
                o_rdy = rdy_c; o_bsy = bsy_c; o_dn = dn_c; o_ov = ov_c;
                o_bcd = 32'(bcd_c); o_seg = 64'(seg_c);
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [63:0] exp_seg(input logic [31:0] bcd, input logic ovf, input int nd);
        logic [63:0] s;
        logic [3:0]  d;
        logic [6:0]  g;
        logic        lead;
        s = '0;
        lead = 1'b1;
        for (int i = nd - 1; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            if (ovf) begin
                g = 7'b0111111;
            end else begin
                g = glyph(d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (d != 4'd0 || i == 0) lead = 1'b0;
                if (lead) g = 7'b1111111;
`endif
            end
            s[7*i +: 7] = g;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int s, input logic [15:0] v, input logic vld);
        case (s)
            0: begin bin_a = v; val_a = vld; end
            1: begin bin_b = v; val_b = vld; end
            default: begin bin_c = v[0]; val_c = vld; end
        endcase
    endtask

    task automatic convert(input int s, input logic [15:0] v, input logic [31:0] exp_bcd,
                           input logic exp_ovf, input int nd, input int lat, input string tag);
        logic [31:0] prev_bcd;
        logic [63:0] prev_seg;
        int          w;
        int          k;
        sel = s;
        #0;
        prev_bcd = o_bcd;
        prev_seg = o_seg;
        w = 0;
        while (!o_rdy && w < 50) begin
            tick();
            w++;
        end
        check_val({tag, "_ready"}, 64'(o_rdy), 64'd1);
        drive(s, v, 1'b1);
        tick();
        drive(s, 16'h0, 1'b0);
        k = 0;
        while (k < lat + 10) begin
            tick();
            k++;
            if (k == lat / 2 && !o_dn) begin
                check_val({tag, "_busy_mid"}, 64'(o_bsy), 64'd1);
                check_val({tag, "_bcd_hold"}, 64'(o_bcd), 64'(prev_bcd));
                check_val({tag, "_seg_hold"}, o_seg, prev_seg);
            end
            if (o_dn) break;
        end
        check_val({tag, "_latency"}, 64'(k), 64'(lat));
        check_val({tag, "_bcd"}, 64'(o_bcd), 64'(exp_bcd));
        check_val({tag, "_ovf"}, 64'(o_ov), 64'(exp_ovf));
        check_val({tag, "_seg"}, o_seg, exp_seg(exp_bcd, exp_ovf, nd));
        check_val({tag, "_ready_after"}, 64'(o_rdy), 64'd1);
        tick();
        check_val({tag, "_done_pulse"}, 64'(o_dn), 64'd0);
    endtask

    logic [15:0] tbl_v [4] = '{16'd7, 16'd300, 16'd4095, 16'd50000};
    logic [31:0] tbl_b [4] = '{32'h00007, 32'h00300, 32'h04095, 32'h50000};

    initial begin : main
        int q[$];
        int n_done;
        int idx;

        tick();
        tick();
        sel = 0;
        #0;
        check_val("rst_ready", 64'(o_rdy), 64'd1);
        check_val("rst_busy", 64'(o_bsy), 64'd0);
        check_val("rst_done", 64'(o_dn), 64'd0);
        check_val("rst_ovf", 64'(o_ov), 64'd0);
        check_val("rst_bcd", 64'(o_bcd), 64'd0);
        check_val("rst_seg_a", o_seg, exp_seg(32'h0, 1'b0, 5));
        check_val("rst_seg_b", 64'(seg_b), exp_seg(32'h0, 1'b0, 4));
        reset = 1'b0;
        tick();

        convert(0, 16'd1234,  32'h01234, 1'b0, 5, 17, "a1234");
        convert(0, 16'd65535, 32'h65535, 1'b0, 5, 17, "a65535");
        convert(0, 16'd0,     32'h00000, 1'b0, 5, 17, "a0");
        convert(0, 16'd42,    32'h00042, 1'b0, 5, 17, "a42");

        convert(1, 16'd9999,  32'h9999, 1'b0, 4, 17, "b9999");
        convert(1, 16'd10000, 32'hFFFF, 1'b1, 4, 17, "b10000");
        convert(1, 16'd123,   32'h0123, 1'b0, 4, 17, "b123");

        convert(2, 16'd1, 32'h1, 1'b0, 1, 2, "c1");
        convert(2, 16'd0, 32'h0, 1'b0, 1, 2, "c0");

        // Continuous valid with a rotating input; each done must match its own accept.
        sel = 0;
        n_done = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (dn_a) begin
                if (q.size() > 0) begin
                    idx = q.pop_front();
                    check_val("stream_bcd", 64'(bcd_a), 64'(tbl_b[idx]));
                end else begin
                    check_val("stream_spurious_done", 64'd1, 64'd0);
                end
                n_done++;
            end
            if (cyc < 80) begin
                drive(0, tbl_v[cyc % 4], 1'b1);
                if (rdy_a) q.push_back(cyc % 4);
            end else begin
                drive(0, 16'h0, 1'b0);
            end
            tick();
        end
        check_val("stream_done_count", 64'(n_done >= 4), 64'd1);
        check_val("stream_queue_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset in the middle of a conversion.
        drive(0, 16'd777, 1'b1);
        tick();
        drive(0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        #1;
        check_val("midrst_ready", 64'(rdy_a), 64'd1);
        check_val("midrst_busy", 64'(bsy_a), 64'd0);
        check_val("midrst_done", 64'(dn_a), 64'd0);
        check_val("midrst_ovf", 64'(ov_a), 64'd0);
        check_val("midrst_bcd", 64'(bcd_a), 64'd0);
        check_val("midrst_seg", 64'(seg_a), exp_seg(32'h0, 1'b0, 5));
        tick();
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (dn_a) n_done++;
        end
        check_val("midrst_no_done", 64'(n_done), 64'd0);
        convert(0, 16'd1234, 32'h01234, 1'b0, 5, 17, "a1234_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
